// File: rtl/lock_code_if.sv
// Digit-entry bus between the keypad decoder (master) and the lock code checker (slave).
// Widths follow the checker's DIGITS / DIGIT_W / MAX_TRIES parameters.
interface lock_code_if #(
   parameter int DIGITS    = 3,
   parameter int DIGIT_W   = 4,
   parameter int MAX_TRIES = 3
) ();
   localparam int CNT_W  = $clog2(DIGITS + 1);
   localparam int FAIL_W = $clog2(MAX_TRIES + 1);

   logic                      digit_valid;
   logic [DIGIT_W-1:0]        digit_in;
   logic                      clear;
   logic [DIGITS*DIGIT_W-1:0] code;
   logic                      unlocked;
   logic                      alarm;
   logic                      fail;
   logic [CNT_W-1:0]          digit_cnt;
   logic [FAIL_W-1:0]         fail_cnt;

   modport master (
      output digit_valid, digit_in, clear, code,
      input  unlocked, alarm, fail, digit_cnt, fail_cnt
   );

   modport slave (
      input  digit_valid, digit_in, clear, code,
      output unlocked, alarm, fail, digit_cnt, fail_cnt
   );
endinterface

// File: rtl/lock_code_checker.sv
// Sequential code-entry checker with failure counting and timed lockout.
// Optional feature: define LOCK_AUTO_RELOCK_EN to auto-relock RELOCK_CYCLES after opening.
module lock_code_checker #(
   parameter int DIGITS         = 3,
   parameter int DIGIT_W        = 4,
   parameter int MAX_TRIES      = 3,
   parameter int LOCKOUT_CYCLES = 16,
   parameter int RELOCK_CYCLES  = 64
) (
   input logic        clk,
   input logic        rst,
   lock_code_if.slave bus
);
   localparam int ENTRY_W = DIGITS * DIGIT_W;
   localparam int CNT_W   = $clog2(DIGITS + 1);
   localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
`ifdef LOCK_AUTO_RELOCK_EN
   localparam int TMR_MAX = (RELOCK_CYCLES > LOCKOUT_CYCLES) ? RELOCK_CYCLES : LOCKOUT_CYCLES;
`else
   localparam int TMR_MAX = LOCKOUT_CYCLES;
`endif
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   if (DIGITS < 1 || MAX_TRIES < 1 || LOCKOUT_CYCLES < 1 || RELOCK_CYCLES < 1) begin : g_param_check
      $error("lock_code_checker: DIGITS, MAX_TRIES, LOCKOUT_CYCLES and RELOCK_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {ST_ENTRY, ST_OPEN, ST_LOCKOUT} state_e;

   state_e              state_q, state_d;
   logic [ENTRY_W-1:0]  entry_q, entry_d;
   logic [CNT_W-1:0]    digit_cnt_q, digit_cnt_d;
   logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                fail_q, fail_d;
   logic                unlocked_q, alarm_q;

   logic [ENTRY_W+DIGIT_W-1:0] shifted;
   logic [ENTRY_W-1:0]         entry_next;

   // The oldest digit falls off the top; the full entry is compared including this cycle's digit.
   assign shifted    = {entry_q, bus.digit_in};
   assign entry_next = shifted[ENTRY_W-1:0];

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
      state_d     = state_q;
      entry_d     = entry_q;
      digit_cnt_d = digit_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      timer_d     = timer_q;
      fail_d      = 1'b0;

      unique case (state_q)
         ST_ENTRY: begin
            if (bus.clear) begin
               digit_cnt_d = '0;
            end else if (bus.digit_valid) begin
               entry_d = entry_next;
               if (digit_cnt_q < CNT_W'(DIGITS - 1)) begin
                  digit_cnt_d = digit_cnt_q + 1'b1;
               end else begin
                  digit_cnt_d = '0;
                  if (entry_next == bus.code) begin
                     state_d    = ST_OPEN;
                     fail_cnt_d = '0;
`ifdef LOCK_AUTO_RELOCK_EN
                     timer_d    = TMR_W'(RELOCK_CYCLES - 1);
`endif
                  end else begin
                     fail_d     = 1'b1;
                     fail_cnt_d = fail_cnt_q + 1'b1;
                     if (fail_cnt_d == FAIL_W'(MAX_TRIES)) begin
                        state_d = ST_LOCKOUT;
                        timer_d = TMR_W'(LOCKOUT_CYCLES - 1);
                     end
                  end
               end
            end
         end
         ST_OPEN: begin
            if (bus.clear) begin
               state_d = ST_ENTRY;
`ifdef LOCK_AUTO_RELOCK_EN
            end else if (timer_q == '0) begin
               state_d = ST_ENTRY;
            end else begin
               timer_d = timer_q - 1'b1;
`endif
            end
         end
         ST_LOCKOUT: begin
            if (timer_q == '0) begin
               state_d    = ST_ENTRY;
               fail_cnt_d = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = ST_ENTRY;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ENTRY;
         entry_q     <= '0;
         digit_cnt_q <= '0;
         fail_cnt_q  <= '0;
         timer_q     <= '0;
         fail_q      <= 1'b0;
         unlocked_q  <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         entry_q     <= entry_d;
         digit_cnt_q <= digit_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         timer_q     <= timer_d;
         fail_q      <= fail_d;
         unlocked_q  <= (state_d == ST_OPEN);
         alarm_q     <= (state_d == ST_LOCKOUT);
      end
   end

   assign bus.unlocked  = unlocked_q;
   assign bus.alarm     = alarm_q;
   assign bus.fail      = fail_q;
   assign bus.digit_cnt = digit_cnt_q;
   assign bus.fail_cnt  = fail_cnt_q;
endmodule

// File: tb/tb_lock_code_checker.sv
// Scoreboard bench for lock_code_checker: a driver feeds one input vector per cycle and queues the
// reference model's expected outputs; a monitor pops and compares after every rising edge.
module tb_lock_code_checker;
   localparam int DIGITS         = 3;
   localparam int DIGIT_W        = 4;
   localparam int MAX_TRIES      = 3;
   localparam int LOCKOUT_CYCLES = 16;
   localparam int RELOCK_CYCLES  = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lock_code_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES)) bus ();

   lock_code_checker #(
      .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES),
      .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .RELOCK_CYCLES(RELOCK_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic unlocked;
      logic alarm;
      logic fail;
      int   digit_cnt;
      int   fail_cnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: digits typed so far, open flag and remaining lockout / relock cycles.
   int   entered[$];
   bit   m_open;
   bit   m_fail;
   int   m_fails;
   int   m_lock_left;
   int   m_open_left;
   logic [DIGITS*DIGIT_W-1:0] cur_code;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      entered.delete();
      m_open      = 0;
      m_fail      = 0;
      m_fails     = 0;
      m_lock_left = 0;
      m_open_left = 0;
   endfunction

   function automatic void model_step(bit v, int d, bit clr, int c);
      int val;
      m_fail = 0;
      if (m_lock_left > 0) begin
         m_lock_left--;
         if (m_lock_left == 0) m_fails = 0;
      end else if (m_open) begin
         if (clr) m_open = 0;
`ifdef LOCK_AUTO_RELOCK_EN
         else begin
            m_open_left--;
            if (m_open_left == 0) m_open = 0;
         end
`endif
      end else if (clr) begin
         entered.delete();
      end else if (v) begin
         entered.push_back(d);
         if (entered.size() == DIGITS) begin
            val = 0;
            foreach (entered[i]) val = val * (1 << DIGIT_W) + entered[i];
            entered.delete();
            if (val == c) begin
               m_open      = 1;
               m_fails     = 0;
               m_open_left = RELOCK_CYCLES;
            end else begin
               m_fail = 1;
               m_fails++;
               if (m_fails == MAX_TRIES) m_lock_left = LOCKOUT_CYCLES;
            end
         end
      end
   endfunction

   function automatic exp_t model_outputs();
      exp_t e;
      e.unlocked  = m_open;
      e.alarm     = (m_lock_left > 0);
      e.fail      = m_fail;
      e.digit_cnt = entered.size();
      e.fail_cnt  = m_fails;
      return e;
   endfunction

   task automatic step(input bit v, input int d, input bit clr);
      @(negedge clk);
      rst             = 1'b0;
      bus.digit_valid = v;
      bus.digit_in    = DIGIT_W'(d);
      bus.clear       = clr;
      bus.code        = cur_code;
      model_step(v, d, clr, int'(cur_code));
      sb_q.push_back(model_outputs());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   task automatic send_entry(input int a, input int b, input int c);
      step(1, a, 0);
      step(1, b, 0);
      step(1, c, 0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst             = 1'b1;
      bus.digit_valid = 1'b0;
      bus.clear       = 1'b0;
      #1;
      check("rst_unlocked", bus.unlocked, 0);
      check("rst_alarm", bus.alarm, 0);
      check("rst_fail", bus.fail, 0);
      check("rst_digit_cnt", bus.digit_cnt, 0);
      check("rst_fail_cnt", bus.fail_cnt, 0);
      model_reset();
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         sb_q.push_back(model_outputs());
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("unlocked", bus.unlocked, e.unlocked);
            check("alarm", bus.alarm, e.alarm);
            check("fail", bus.fail, e.fail);
            check("digit_cnt", bus.digit_cnt, e.digit_cnt);
            check("fail_cnt", bus.fail_cnt, e.fail_cnt);
         end
      end
   end

   initial begin : driver
      int r;
      int dg;
      rst             = 1'b1;
      bus.digit_valid = 1'b0;
      bus.digit_in    = '0;
      bus.clear       = 1'b0;
      cur_code        = 12'h123;
      bus.code        = cur_code;
      model_reset();
      do_reset(3);

      // Correct entry; open must persist (or relock when the feature is built) until clear.
      send_entry(1, 2, 3);
      idle(210);
      step(0, 0, 1);
      idle(2);

      // Three failures into lockout, digits during lockout ignored, then a correct entry.
      for (int k = 0; k < 3; k++) begin
         send_entry(1, 2, 4);
         if (k < 2) idle(1);
      end
      for (int k = 0; k < 6; k++) step(1, 1 + k % 3, k == 3);
      idle(14);
      send_entry(1, 2, 3);
      idle(2);
      step(0, 0, 1);

      // Clear mid-entry, then clear colliding with a digit.
      send_entry(1, 2, 0);
      step(0, 0, 1);
      step(1, 1, 0);
      step(1, 2, 0);
      step(0, 0, 1);
      send_entry(1, 2, 3);
      step(0, 0, 1);
      step(1, 1, 0);
      step(1, 2, 1);
      send_entry(1, 2, 3);
      step(0, 0, 1);

      // Two failures then success resets the failure count.
      send_entry(4, 5, 6);
      send_entry(1, 2, 4);
      send_entry(1, 2, 3);
      idle(2);
      step(0, 0, 1);
      idle(2);

      // Reset in the middle of a lockout.
      send_entry(9, 9, 9);
      send_entry(9, 9, 9);
      send_entry(9, 9, 9);
      idle(5);
      do_reset(2);
      send_entry(1, 2, 3);
      step(0, 0, 1);

      // Randomised traffic biased towards correct digits so all three states are exercised.
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r == 99) cur_code = DIGITS*DIGIT_W'($urandom);
         if (r < 8) begin
            step(0, 0, 1);
         end else if (r < 80) begin
            if ($urandom_range(0, 99) < 75 && entered.size() < DIGITS)
               dg = int'((cur_code >> (DIGIT_W * (DIGITS - 1 - entered.size()))) & ((1 << DIGIT_W) - 1));
            else
               dg = int'($urandom_range(0, (1 << DIGIT_W) - 1));
            step(1, dg, ($urandom_range(0, 99) < 3));
         end else begin
            step(0, 0, 0);
         end
      end

      idle(2);
      repeat (4) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expected entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lock_code_checker.md
# lock_code_checker

Sequential, parametrised code-entry checker for the digit lock. It accepts digits one at a time over a valid strobe and compares the completed entry against a stored code. Consecutive failures are counted and trigger a timed lockout with an alarm. It sits between the keypad digit decoder and the lock actuator/alarm drivers, and generalises the fixed 12-bit equality compare to any digit count and width.

## Interface
- DIGITS, 3: digits per code; must be ≥1.
- DIGIT_W, 4: bits per digit; raw compare, any value is legal.
- MAX_TRIES, 3: consecutive failures that trigger lockout; must be ≥1.
- LOCKOUT_CYCLES, 16: lockout duration in clk cycles; must be ≥1.
- RELOCK_CYCLES, 64: auto-relock delay; used only with LOCK_AUTO_RELOCK_EN.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- digit_valid  in  1  digit_in is presented this cycle.
- digit_in  in  DIGIT_W  entered digit.
- clear  in  1  abandon the partial entry, or relock when open.
- code  in  DIGITS*DIGIT_W  stored code; first digit in the MS slice; sampled only at check time.
- unlocked  out  1  registered; high while in OPEN.
- alarm  out  1  registered; high while in LOCKOUT.
- fail  out  1  registered one-cycle pulse on each mismatch.
- digit_cnt  out  clog2(DIGITS+1)  digits accepted in the current entry.
- fail_cnt  out  clog2(MAX_TRIES+1)  consecutive failures.

## Operation
- States: ENTRY, OPEN, LOCKOUT. Reset → ENTRY, shift register 0, all outputs 0.
- ENTRY, digit_valid and no clear:
  - Shift digit_in into the LS slice of the entry register.
  - If digit_cnt < DIGITS-1, increment digit_cnt.
  - Otherwise this is the final digit. Compare {entry[DIGITS-1 prefix], digit_in} against code, then set digit_cnt to 0.
- Match on the final digit: go to OPEN, set fail_cnt to 0.
- Mismatch on the final digit:
  - Pulse fail and increment fail_cnt.
  - If the new fail_cnt equals MAX_TRIES: go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1.
  - Otherwise stay in ENTRY.
- clear in ENTRY: set digit_cnt to 0. The shift register contents are don't-care. No failure is counted.
- clear and digit_valid in the same cycle: clear wins and the digit is dropped.
- OPEN: digit_valid is ignored. clear → ENTRY, with digit_cnt staying 0.
- LOCKOUT: digit_valid and clear are ignored. The timer decrements every cycle. When the timer is 0, go to ENTRY and set fail_cnt to 0.
- Entry register and comparator span DIGITS*DIGIT_W bits. There are no intermediate digit-range checks.

## Timing
- A final digit accepted at edge N gives unlocked, or fail plus the fail_cnt update, visible after edge N; latency is 1 cycle.
- alarm rises with the failing edge and stays high for exactly LOCKOUT_CYCLES cycles. The first digit is accepted on the cycle after alarm falls.
- fail is high for exactly one cycle per mismatch, including the mismatch that enters LOCKOUT.
- Back-to-back digit_valid is accepted every cycle with no bubbles.
- rst asserted at any time, including mid-entry or mid-lockout, immediately forces all outputs to 0 and the state to ENTRY.

## Configuration
- LOCK_AUTO_RELOCK_EN defined:
  - OPEN loads a relock timer with RELOCK_CYCLES-1 on entry.
  - When the timer reaches 0, the block returns to ENTRY, so unlocked is high for RELOCK_CYCLES cycles.
  - clear still relocks early.
- LOCK_AUTO_RELOCK_EN undefined: the relock timer is not built, and OPEN persists until clear or rst.

## Test plan
- Defaults, code=12'h123, digits 1,2,3 on consecutive cycles → unlocked=1 one cycle after the digit 3 edge, fail_cnt=0, digit_cnt=0.
- Entry 1,2,4 three times with code 12'h123 → fail pulses 3 times, fail_cnt goes 1,2,3, alarm high exactly 16 cycles, digits sent during lockout are ignored, then fail_cnt=0 and a correct 1,2,3 unlocks.
- Digits 1,2 then clear, then 1,2,3 → unlocked=1 with no fail pulse. A separate run with clear and digit_valid in the same cycle shows the digit dropped and digit_cnt=0.
- Two failures then a correct entry → fail_cnt resets to 0. Then clear → unlocked=0 and state is ENTRY.
- rst pulsed mid-lockout → alarm=0, fail_cnt=0, and the next correct entry unlocks.
- With LOCK_AUTO_RELOCK_EN and RELOCK_CYCLES=64: unlocked high exactly 64 cycles after a correct entry. Without the macro: unlocked stays high for 200 or more cycles until clear.
